// File: rtl/mem_1r1w_ctrl.sv
// Sequencer and arbiter for a single 1R1W memory macro: clears every entry after reset,
// then serves one writer and two round-robin readers with a fixed 1-cycle read latency.
module mem_1r1w_ctrl #(
    parameter int unsigned      DEPTH      = 48,
    parameter int unsigned      WIDTH      = 64,
    parameter int unsigned      ADDR_W     = 6,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,

    input  logic              rd0_valid,
    output logic              rd0_ready,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic              rd1_valid,
    output logic              rd1_ready,
    input  logic [ADDR_W-1:0] rd1_addr,

    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_err,

    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    input  logic [WIDTH-1:0]  R0_data,
    output logic [ADDR_W-1:0] W0_addr,
    output logic              W0_en,
    output logic [WIDTH-1:0]  W0_data
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Range checks are done one bit wider so addresses up to 2**ADDR_W-1 compare correctly
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic              rsp_pend_q, rsp_pend_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_err_q, rsp_err_d;
    logic              byp_q, byp_d;
    logic [WIDTH-1:0]  byp_data_q, byp_data_d;

    logic              running;
    logic              initing;
    logic              wr_fire;
    logic              wr_in_range;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_in_range;
    logic              rsp_live;

    always_comb begin
        running      = (state_q == ST_RUN) && !reset;
        initing      = (state_q == ST_INIT) && !reset;
        wr_fire      = running && wr_valid;
        wr_in_range  = ({1'b0, wr_addr} < DEPTH_X);
        gnt0         = running && rd0_valid && (!rd1_valid || (prio_q == 1'b0));
        gnt1         = running && rd1_valid && (!rd0_valid || (prio_q == 1'b1));
        gnt_any      = gnt0 || gnt1;
        gnt_addr     = gnt1 ? rd1_addr : rd0_addr;
        gnt_in_range = ({1'b0, gnt_addr} < DEPTH_X);
        rsp_live     = rsp_pend_q && !reset;
    end

    always_comb begin
        init_done = running;
        wr_ready  = running;
        rd0_ready = gnt0;
        rd1_ready = gnt1;

        W0_en     = initing || (wr_fire && wr_in_range);
        W0_addr   = initing ? cnt_q : wr_addr;
        W0_data   = initing ? INIT_VALUE : wr_data;

        R0_en     = gnt_any && gnt_in_range;
        R0_addr   = gnt_addr;

        rsp_valid = rsp_live;
        rsp_id    = rsp_live ? rsp_id_q : 1'b0;
        rsp_err   = rsp_live ? rsp_err_q : 1'b0;
        rsp_data  = '0;
        if (rsp_live && !rsp_err_q) begin
            rsp_data = byp_q ? byp_data_q : R0_data;
        end
    end

    // The macro's same-cycle same-address behaviour is undefined, so a colliding
    // write is captured here and substituted for the read data one cycle later.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prio_d     = prio_q;
        rsp_pend_d = gnt_any;
        rsp_id_d   = gnt1;
        rsp_err_d  = gnt_any && !gnt_in_range;
        byp_d      = gnt_any && gnt_in_range && wr_fire && wr_in_range && (wr_addr == gnt_addr);
        byp_data_d = wr_data;

        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end

        if (gnt0 && rd1_valid) begin
            prio_d = 1'b1;
        end else if (gnt1 && rd0_valid) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            prio_q     <= 1'b0;
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

endmodule

// File: tb/tb_mem_1r1w_ctrl.sv
// Directed bench for mem_1r1w_ctrl with a behavioural 48x64 registered-read memory attached.
module tb_mem_1r1w_ctrl;

    logic        clock;
    logic        reset;
    logic        init_done;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rd0_valid;
    logic        rd0_ready;
    logic [5:0]  rd0_addr;
    logic        rd1_valid;
    logic        rd1_ready;
    logic [5:0]  rd1_addr;
    logic        rsp_valid;
    logic        rsp_id;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic [5:0]  R0_addr;
    logic        R0_en;
    logic [63:0] R0_data;
    logic [5:0]  W0_addr;
    logic        W0_en;
    logic [63:0] W0_data;

    logic [63:0] mem [0:47];

    int checkCount;
    int passCount;

    mem_1r1w_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .init_done (init_done),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd0_valid (rd0_valid),
        .rd0_ready (rd0_ready),
        .rd0_addr  (rd0_addr),
        .rd1_valid (rd1_valid),
        .rd1_ready (rd1_ready),
        .rd1_addr  (rd1_addr),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .R0_addr   (R0_addr),
        .R0_en     (R0_en),
        .R0_data   (R0_data),
        .W0_addr   (W0_addr),
        .W0_en     (W0_en),
        .W0_data   (W0_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory macro stand-in: a same-cycle read returns the old contents
    always @(posedge clock) begin
        if (W0_en && (W0_addr < 6'd48)) mem[W0_addr] <= W0_data;
        if (R0_en) R0_data <= (R0_addr < 6'd48) ? mem[R0_addr] : 64'hBADBADBADBADBAD0;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst,
                                 input logic wv, input logic [5:0] wa, input logic [63:0] wd,
                                 input logic r0v, input logic [5:0] r0a,
                                 input logic r1v, input logic [5:0] r1a);
        @(negedge clock);
        reset     = rst;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        rd0_valid = r0v;
        rd0_addr  = r0a;
        rd1_valid = r1v;
        rd1_addr  = r1a;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 1'b0, 6'd0);
    endtask

    // Runs init cycles first..last with readers/writer requesting, which must all be ignored
    task automatic checkInitCycles(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            applyStimulus(1'b0, 1'b1, 6'd9, 64'h77, 1'b1, 6'd3, 1'b1, 6'd4);
            checkOutput("init_w0en", {63'd0, W0_en}, 64'd1);
            checkOutput("init_w0addr", {58'd0, W0_addr}, 64'(k));
            checkOutput("init_w0data", W0_data, 64'd0);
            checkOutput("init_done_lo", {63'd0, init_done}, 64'd0);
            checkOutput("init_readys", {61'd0, wr_ready, rd0_ready, rd1_ready}, 64'd0);
            checkOutput("init_r0en", {63'd0, R0_en}, 64'd0);
        end
    endtask

    task automatic checkInitDone();
        idleCycle();
        checkOutput("init_done_hi", {63'd0, init_done}, 64'd1);
        checkOutput("run_w0en_idle", {63'd0, W0_en}, 64'd0);
        checkOutput("run_wr_ready", {63'd0, wr_ready}, 64'd1);
    endtask

    task automatic checkResponse(input string tag, input logic id, input logic [63:0] data, input logic err);
        checkOutput({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
        checkOutput({tag, "_id"}, {63'd0, rsp_id}, {63'd0, id});
        checkOutput({tag, "_data"}, rsp_data, data);
        checkOutput({tag, "_err"}, {63'd0, rsp_err}, {63'd0, err});
    endtask

    task automatic checkNoResponse(input string tag);
        checkOutput(tag, {rsp_valid, rsp_id, rsp_err, 61'd0} | rsp_data, 64'd0);
    endtask

    initial begin
        logic expG;
        logic prevG;
        checkCount = 0;
        passCount  = 0;
        reset     = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd0_valid = 1'b0;
        rd0_addr  = '0;
        rd1_valid = 1'b0;
        rd1_addr  = '0;

        applyStimulus(1'b1, 1'b1, 6'd1, 64'd5, 1'b1, 6'd1, 1'b0, 6'd0);
        checkOutput("rst_init_done", {63'd0, init_done}, 64'd0);
        checkOutput("rst_readys", {61'd0, wr_ready, rd0_ready, rd1_ready}, 64'd0);
        checkOutput("rst_enables", {62'd0, W0_en, R0_en}, 64'd0);
        checkNoResponse("rst_rsp");

        checkInitCycles(0, 47);
        checkInitDone();

        // Write then read back through reader 0
        applyStimulus(1'b0, 1'b1, 6'd5, 64'hDEADBEEF_CAFEF00D, 1'b0, 6'd0, 1'b0, 6'd0);
        checkOutput("wr5_w0en", {63'd0, W0_en}, 64'd1);
        checkOutput("wr5_w0addr", {58'd0, W0_addr}, 64'd5);
        checkOutput("wr5_w0data", W0_data, 64'hDEADBEEF_CAFEF00D);
        applyStimulus(1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd5, 1'b0, 6'd0);
        checkOutput("rd5_ready", {62'd0, rd0_ready, rd1_ready}, 64'd2);
        checkOutput("rd5_r0en", {63'd0, R0_en}, 64'd1);
        checkOutput("rd5_r0addr", {58'd0, R0_addr}, 64'd5);
        checkNoResponse("rd5_no_early_rsp");
        idleCycle();
        checkResponse("rd5_rsp", 1'b0, 64'hDEADBEEF_CAFEF00D, 1'b0);
        idleCycle();
        checkNoResponse("rd5_rsp_gone");

        // Contested reads alternate starting with reader 0
        applyStimulus(1'b0, 1'b1, 6'd1, 64'h1111, 1'b0, 6'd0, 1'b0, 6'd0);
        applyStimulus(1'b0, 1'b1, 6'd2, 64'h2222, 1'b0, 6'd0, 1'b0, 6'd0);
        prevG = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd1, 1'b1, 6'd2);
            expG = (i % 2) == 1;
            checkOutput("rr_grant", {62'd0, rd0_ready, rd1_ready}, expG ? 64'd1 : 64'd2);
            checkOutput("rr_r0addr", {58'd0, R0_addr}, expG ? 64'd2 : 64'd1);
            if (i > 0) checkResponse("rr_rsp", prevG, prevG ? 64'h2222 : 64'h1111, 1'b0);
            prevG = expG;
        end
        idleCycle();
        checkResponse("rr_rsp_last", 1'b1, 64'h2222, 1'b0);

        // Same-cycle write and read of address 47 must bypass
        applyStimulus(1'b0, 1'b1, 6'd47, 64'h1234, 1'b0, 6'd0, 1'b1, 6'd47);
        checkOutput("byp_grant", {62'd0, rd0_ready, rd1_ready}, 64'd1);
        checkOutput("byp_w0en", {63'd0, W0_en}, 64'd1);
        idleCycle();
        checkResponse("byp_rsp", 1'b1, 64'h1234, 1'b0);
        applyStimulus(1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd47, 1'b0, 6'd0);
        idleCycle();
        checkResponse("byp_reread", 1'b0, 64'h1234, 1'b0);

        // Out-of-range read and write
        applyStimulus(1'b0, 1'b1, 6'd60, 64'hFFFF, 1'b1, 6'd50, 1'b0, 6'd0);
        checkOutput("oor_grant", {62'd0, rd0_ready, rd1_ready}, 64'd2);
        checkOutput("oor_wr_ready", {63'd0, wr_ready}, 64'd1);
        checkOutput("oor_r0en", {63'd0, R0_en}, 64'd0);
        checkOutput("oor_w0en", {63'd0, W0_en}, 64'd0);
        idleCycle();
        checkResponse("oor_rsp", 1'b0, 64'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 1'b1, 6'd5);
        idleCycle();
        checkResponse("oor_mem_intact", 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0);

        // Reset with a read in flight drops the response
        applyStimulus(1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd5, 1'b0, 6'd0);
        checkOutput("inflight_grant", {63'd0, rd0_ready}, 64'd1);
        applyStimulus(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 1'b0, 6'd0);
        checkNoResponse("inflight_rsp_in_reset");
        checkOutput("inflight_init_done", {63'd0, init_done}, 64'd0);
        checkInitCycles(0, 0);
        checkNoResponse("inflight_rsp_after_reset");

        // Reset at init cycle 20 restarts the clear from address 0
        checkInitCycles(1, 19);
        applyStimulus(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 1'b0, 6'd0);
        checkOutput("midinit_rst_w0en", {63'd0, W0_en}, 64'd0);
        checkInitCycles(0, 47);
        checkInitDone();

        // Re-initialisation cleared the earlier data
        applyStimulus(1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd5, 1'b0, 6'd0);
        idleCycle();
        checkResponse("reinit_cleared", 1'b0, 64'd0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
